// File: rtl/mips_pkg.sv
// Shared MIPS-I subset definitions: opcodes, functs, register indices, ALU ops
// and the control decoder used by the single-cycle core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_T0   = 5'd8;
  localparam logic [4:0] REG_T1   = 5'd9;
  localparam logic [4:0] REG_S0   = 5'd16;
  localparam logic [4:0] REG_S1   = 5'd17;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_e;

  typedef struct packed {
    logic    reg_we;
    dst_e    dst;
    logic    alu_imm;
    logic    imm_zext;
    logic    mem_rd;
    logic    mem_we;
    logic    beq;
    logic    bne;
    logic    jump;
    logic    jr;
    alu_op_e alu_op;
  } ctrl_t;

  // Anything not recognised decodes to all-zero controls, i.e. a plain PC+4 NOP.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    c.alu_op = ALU_ADD;
    c.dst    = DST_RD;
    case (op)
      OP_RTYPE: begin
        c.reg_we = 1'b1;
        case (fn)
          FN_ADD, FN_ADDU: c.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_XOR:  c.alu_op = ALU_XOR;
          FN_NOR:  c.alu_op = ALU_NOR;
          FN_SLT:  c.alu_op = ALU_SLT;
          FN_SLTU: c.alu_op = ALU_SLTU;
          FN_SLL:  c.alu_op = ALU_SLL;
          FN_SRL:  c.alu_op = ALU_SRL;
          FN_SRA:  c.alu_op = ALU_SRA;
          FN_JR: begin
            c.reg_we = 1'b0;
            c.jr     = 1'b1;
          end
          default: c.reg_we = 1'b0;
        endcase
      end
      OP_J:   c.jump = 1'b1;
      OP_JAL: begin
        c.jump   = 1'b1;
        c.reg_we = 1'b1;
        c.dst    = DST_RA;
      end
      OP_BEQ: c.beq = 1'b1;
      OP_BNE: c.bne = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c.reg_we   = 1'b1;
        c.dst      = DST_RT;
        c.alu_imm  = 1'b1;
        c.imm_zext = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
        case (op)
          OP_SLTI:  c.alu_op = ALU_SLT;
          OP_SLTIU: c.alu_op = ALU_SLTU;
          OP_ANDI:  c.alu_op = ALU_AND;
          OP_ORI:   c.alu_op = ALU_OR;
          OP_XORI:  c.alu_op = ALU_XOR;
          OP_LUI:   c.alu_op = ALU_LUI;
          default:  c.alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        c.reg_we  = 1'b1;
        c.dst     = DST_RT;
        c.alu_imm = 1'b1;
        c.mem_rd  = 1'b1;
      end
      OP_SW: begin
        c.alu_imm = 1'b1;
        c.mem_we  = 1'b1;
      end
      default: c = c;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_bytemem.sv
// Big-endian byte-array memory: combinational word read, synchronous word write.
// Address wraps modulo BYTES; the low two address bits are ignored.
module mips_bytemem #(
  parameter int unsigned BYTES = 1024
) (
  input  logic        i_clk,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);
  localparam int unsigned AW = $clog2(BYTES);

  logic [7:0]    bytes [0:BYTES-1];
  logic [AW-1:0] w_base;
  logic          w_unused_addr;

  assign w_base        = {i_addr[AW-1:2], 2'b00};
  assign w_unused_addr = ^{i_addr[31:AW], i_addr[1:0]};

  assign o_rdata = {bytes[w_base], bytes[w_base | AW'(1)],
                    bytes[w_base | AW'(2)], bytes[w_base | AW'(3)]};

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      bytes[w_base]          <= i_wdata[31:24];
      bytes[w_base | AW'(1)] <= i_wdata[23:16];
      bytes[w_base | AW'(2)] <= i_wdata[15:8];
      bytes[w_base | AW'(3)] <= i_wdata[7:0];
    end
  end
endmodule

// File: rtl/mips_ifu.sv
// Instruction fetch: PC register plus read-only instruction memory that is
// loaded by backdoor into imemory.storage.bytes.
module mips_imem #(
  parameter int unsigned BYTES = 1024
) (
  input  logic        i_clk,
  input  logic [31:0] i_addr,
  output logic [31:0] o_instr
);
  mips_bytemem #(.BYTES(BYTES)) storage (
    .i_clk   (i_clk),
    .i_we    (1'b0),
    .i_addr  (i_addr),
    .i_wdata ('0),
    .o_rdata (o_instr)
  );
endmodule

module mips_ifu #(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_next_pc,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);
  logic [31:0] r_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_pc <= RESET_PC;
    else       r_pc <= i_next_pc;
  end

  assign o_pc = r_pc;

  mips_imem #(.BYTES(IMEM_BYTES)) imemory (
    .i_clk   (i_clk),
    .i_addr  (r_pc),
    .o_instr (o_instr)
  );
endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// asynchronous clear. $0 reads as zero and ignores writes.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd
);
  logic [31:0] registers [0:31];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 32; i++) registers[i] <= '0;
    end else if (i_we && (i_wa != REG_ZERO)) begin
      registers[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == REG_ZERO) ? '0 : registers[i_ra1];
  assign o_rd2 = (i_ra2 == REG_ZERO) ? '0 : registers[i_ra2];
endmodule

// File: rtl/mips_single_cycle_cpu.sv
// Single-cycle MIPS-I subset core: every rising edge out of reset commits one
// instruction (register write, data-memory write and PC update together).
module mips_single_cycle_cpu
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int unsigned DMEM_BYTES = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  output logic [31:0] instr
);
  logic [31:0] w_next_pc, w_pc4, w_br_target, w_imm, w_alu_b, w_alu_y;
  logic [31:0] w_rd1, w_rd2, w_load, w_wd;
  logic [4:0]  w_wa;
  logic        w_taken;
  ctrl_t       w_ctrl;

  mips_ifu #(.IMEM_BYTES(IMEM_BYTES), .RESET_PC(RESET_PC)) IFU (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_next_pc (w_next_pc),
    .o_pc      (pc),
    .o_instr   (instr)
  );

  assign w_ctrl = decode(instr[31:26], instr[5:0]);

  mips_regfile registers (
    .i_clk (clk),
    .i_rst (reset),
    .i_ra1 (instr[25:21]),
    .i_ra2 (instr[20:16]),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (w_ctrl.reg_we),
    .i_wa  (w_wa),
    .i_wd  (w_wd)
  );

  assign w_imm   = w_ctrl.imm_zext ? {16'h0000, instr[15:0]}
                                   : {{16{instr[15]}}, instr[15:0]};
  assign w_alu_b = w_ctrl.alu_imm ? w_imm : w_rd2;

  always_comb begin
    w_alu_y = '0;
    case (w_ctrl.alu_op)
      ALU_ADD:  w_alu_y = w_rd1 + w_alu_b;
      ALU_SUB:  w_alu_y = w_rd1 - w_alu_b;
      ALU_AND:  w_alu_y = w_rd1 & w_alu_b;
      ALU_OR:   w_alu_y = w_rd1 | w_alu_b;
      ALU_XOR:  w_alu_y = w_rd1 ^ w_alu_b;
      ALU_NOR:  w_alu_y = ~(w_rd1 | w_alu_b);
      ALU_SLT:  w_alu_y = {31'b0, $signed(w_rd1) < $signed(w_alu_b)};
      ALU_SLTU: w_alu_y = {31'b0, w_rd1 < w_alu_b};
      ALU_SLL:  w_alu_y = w_rd2 << instr[10:6];
      ALU_SRL:  w_alu_y = w_rd2 >> instr[10:6];
      ALU_SRA:  w_alu_y = $unsigned($signed(w_rd2) >>> instr[10:6]);
      ALU_LUI:  w_alu_y = {instr[15:0], 16'h0000};
      default:  w_alu_y = '0;
    endcase
  end

  // Store enable is gated by reset because the memory itself has no reset path.
  mips_bytemem #(.BYTES(DMEM_BYTES)) dmem (
    .i_clk   (clk),
    .i_we    (w_ctrl.mem_we & ~reset),
    .i_addr  (w_alu_y),
    .i_wdata (w_rd2),
    .o_rdata (w_load)
  );

  always_comb begin
    w_wa = instr[15:11];
    w_wd = w_alu_y;
    case (w_ctrl.dst)
      DST_RT: w_wa = instr[20:16];
      DST_RA: w_wa = REG_RA;
      default: w_wa = instr[15:11];
    endcase
    if (w_ctrl.dst == DST_RA) w_wd = w_pc4;
    else if (w_ctrl.mem_rd)   w_wd = w_load;
  end

  assign w_pc4       = pc + 32'd4;
  assign w_br_target = w_pc4 + {w_imm[29:0], 2'b00};
  assign w_taken     = (w_ctrl.beq && (w_rd1 == w_rd2)) ||
                       (w_ctrl.bne && (w_rd1 != w_rd2));

  always_comb begin
    w_next_pc = w_pc4;
    if (w_ctrl.jr)        w_next_pc = w_rd1;
    else if (w_ctrl.jump) w_next_pc = {w_pc4[31:28], instr[25:0], 2'b00};
    else if (w_taken)     w_next_pc = w_br_target;
  end
endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// Self-checking bench for mips_single_cycle_cpu: programs are loaded by backdoor,
// expected state is queued per commit cycle and compared after each edge.
module tb_mips_single_cycle_cpu;
  import mips_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc, instr;

  always #5 clk = ~clk;

  mips_single_cycle_cpu #(
    .IMEM_BYTES (1024),
    .DMEM_BYTES (1024),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pc    (pc),
    .instr (instr)
  );

  typedef enum int {K_REG, K_PC, K_DMEM, K_INSTR} kind_e;
  typedef struct {
    int unsigned cyc;
    kind_e       kind;
    int unsigned idx;
    logic [31:0] exp;
    string       name;
  } chk_t;
  typedef struct {
    logic [4:0]  r;
    logic [31:0] v;
  } rv_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  chk_t        sb[$];
  logic [31:0] prog [0:63];

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  function automatic logic [31:0] peek(input kind_e k, input int unsigned idx);
    logic [9:0] a;
    a = idx[9:0];
    case (k)
      K_REG:   return dut.registers.registers[idx[4:0]];
      K_PC:    return pc;
      K_INSTR: return instr;
      default: return {dut.dmem.bytes[a], dut.dmem.bytes[a + 10'd1],
                       dut.dmem.bytes[a + 10'd2], dut.dmem.bytes[a + 10'd3]};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_at(input int unsigned c, input kind_e k, input int unsigned idx,
                           input logic [31:0] exp, input string name);
    chk_t e;
    e.cyc = c; e.kind = k; e.idx = idx; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain();
    chk_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check(e.name, peek(e.kind, e.idx), e.exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = '0;
  endtask

  task automatic load_imem();
    for (int i = 0; i < 1024; i++) dut.IFU.imemory.storage.bytes[i] = 8'h00;
    for (int w = 0; w < 64; w++) begin
      dut.IFU.imemory.storage.bytes[4*w]     = prog[w][31:24];
      dut.IFU.imemory.storage.bytes[4*w + 1] = prog[w][23:16];
      dut.IFU.imemory.storage.bytes[4*w + 2] = prog[w][15:8];
      dut.IFU.imemory.storage.bytes[4*w + 3] = prog[w][7:0];
    end
  endtask

  task automatic start_prog();
    reset = 1'b1;
    load_imem();
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    drain();
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      drain();
    end
  endtask

  task automatic finish_prog();
    chk_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s not reached within budget (required at cycle %0d)", e.name, e.cyc);
    end
  endtask

  task automatic load_addi_prog();
    clear_prog();
    prog[0] = enc_i(OP_ADDI, REG_ZERO, REG_S0, 16'd0);
    prog[1] = enc_i(OP_ADDI, REG_ZERO, REG_S1, 16'd3);
    prog[2] = enc_i(OP_ADDI, REG_ZERO, REG_T0, 16'd255);
    prog[3] = enc_i(OP_ADDI, REG_ZERO, REG_T1, 16'hFFFD);
  endtask

  task automatic expect_addi_final(input int unsigned c);
    expect_at(c, K_REG, REG_S0, 32'h0000_0000, "addi_s0");
    expect_at(c, K_REG, REG_S1, 32'h0000_0003, "addi_s1");
    expect_at(c, K_REG, REG_T0, 32'h0000_00FF, "addi_t0");
    expect_at(c, K_REG, REG_T1, 32'hFFFF_FFFD, "addi_t1");
    expect_at(c, K_PC,  0,      32'h0000_0010, "addi_pc");
  endtask

  rv_t rtab [0:21];

  initial begin
    // ---- addi load, with reset-state checks ----
    load_addi_prog();
    expect_at(0, K_PC,    0,      32'h0000_0000, "reset_pc");
    expect_at(0, K_INSTR, 0,      32'h2010_0000, "reset_instr");
    expect_at(0, K_REG,   REG_S1, 32'h0000_0000, "reset_s1");
    expect_at(1, K_PC,    0,      32'h0000_0004, "first_commit_pc");
    expect_addi_final(4);
    start_prog();
    step(4);
    finish_prog();

    // ---- R-type and immediate ALU table ----
    clear_prog();
    prog[0]  = enc_i(OP_ADDI, 5'd0, REG_T0, 16'd7);
    prog[1]  = enc_i(OP_ADDI, 5'd0, REG_T1, 16'hFFFE);
    prog[2]  = enc_r(FN_ADD,  REG_T0, REG_T1, 5'd16, 5'd0);
    prog[3]  = enc_r(FN_SUB,  REG_T0, REG_T1, 5'd17, 5'd0);
    prog[4]  = enc_r(FN_SLT,  REG_T0, REG_T1, 5'd18, 5'd0);
    prog[5]  = enc_r(FN_SLTU, REG_T0, REG_T1, 5'd19, 5'd0);
    prog[6]  = enc_r(FN_NOR,  REG_T0, REG_T1, 5'd20, 5'd0);
    prog[7]  = enc_r(FN_AND,  REG_T0, REG_T1, 5'd14, 5'd0);
    prog[8]  = enc_r(FN_OR,   REG_T0, REG_T1, 5'd15, 5'd0);
    prog[9]  = enc_r(FN_XOR,  REG_T0, REG_T1, 5'd24, 5'd0);
    prog[10] = enc_r(FN_SUBU, REG_T1, REG_T0, 5'd25, 5'd0);
    prog[11] = enc_r(FN_ADDU, REG_T0, REG_T1, 5'd26, 5'd0);
    prog[12] = enc_r(FN_SLL,  5'd0, REG_T0, 5'd23, 5'd4);
    prog[13] = enc_r(FN_SRL,  5'd0, REG_T1, 5'd22, 5'd28);
    prog[14] = enc_r(FN_SRA,  5'd0, REG_T1, 5'd21, 5'd1);
    prog[15] = enc_i(OP_ANDI,  REG_T1, 5'd10, 16'hFFFF);
    prog[16] = enc_i(OP_XORI,  REG_T0, 5'd11, 16'h8000);
    prog[17] = enc_i(OP_SLTIU, REG_T0, 5'd12, 16'hFFFF);
    prog[18] = enc_i(OP_SLTI,  REG_T1, 5'd13, 16'hFFFF);
    prog[19] = enc_i(OP_SLTI,  REG_T0, 5'd3,  16'hFFFF);
    prog[20] = enc_i(OP_SLTIU, REG_T1, 5'd4,  16'h0001);
    prog[21] = enc_i(OP_ADDIU, REG_T1, 5'd5,  16'd3);
    prog[22] = enc_i(OP_ORI,   5'd0,   5'd6,  16'h8001);
    prog[23] = enc_r(FN_SLT,  REG_T1, REG_T0, 5'd7, 5'd0);
    rtab[0]  = '{5'd16, 32'h0000_0005};
    rtab[1]  = '{5'd17, 32'h0000_0009};
    rtab[2]  = '{5'd18, 32'h0000_0000};
    rtab[3]  = '{5'd19, 32'h0000_0001};
    rtab[4]  = '{5'd20, 32'h0000_0000};
    rtab[5]  = '{5'd14, 32'h0000_0006};
    rtab[6]  = '{5'd15, 32'hFFFF_FFFF};
    rtab[7]  = '{5'd24, 32'hFFFF_FFF9};
    rtab[8]  = '{5'd25, 32'hFFFF_FFF7};
    rtab[9]  = '{5'd26, 32'h0000_0005};
    rtab[10] = '{5'd23, 32'h0000_0070};
    rtab[11] = '{5'd22, 32'h0000_000F};
    rtab[12] = '{5'd21, 32'hFFFF_FFFF};
    rtab[13] = '{5'd10, 32'h0000_FFFE};
    rtab[14] = '{5'd11, 32'h0000_8007};
    rtab[15] = '{5'd12, 32'h0000_0001};
    rtab[16] = '{5'd13, 32'h0000_0001};
    rtab[17] = '{5'd3,  32'h0000_0000};
    rtab[18] = '{5'd4,  32'h0000_0000};
    rtab[19] = '{5'd5,  32'h0000_0001};
    rtab[20] = '{5'd6,  32'h0000_8001};
    rtab[21] = '{5'd7,  32'h0000_0001};
    for (int i = 0; i < 22; i++)
      expect_at(24, K_REG, rtab[i].r, rtab[i].v, $sformatf("alu_r%0d", rtab[i].r));
    expect_at(24, K_PC, 0, 32'h0000_0060, "alu_pc");
    start_prog();
    step(24);
    finish_prog();

    // ---- memory: lui/ori/sw/lw, ignored low bits, negative offset ----
    clear_prog();
    prog[0] = enc_i(OP_LUI, 5'd0,   REG_T0, 16'h1234);
    prog[1] = enc_i(OP_ORI, REG_T0, REG_T0, 16'h5678);
    prog[2] = enc_i(OP_SW,  5'd0,   REG_T0, 16'd8);
    prog[3] = enc_i(OP_LW,  5'd0,   REG_S0, 16'd8);
    prog[4] = enc_i(OP_LW,  5'd0,   REG_S1, 16'd11);
    prog[5] = enc_i(OP_ADDI, 5'd0,  REG_T1, 16'd16);
    prog[6] = enc_i(OP_LW,  REG_T1, 5'd18,  16'hFFF8);
    expect_at(1, K_REG,  REG_T0, 32'h1234_0000, "lui_t0");
    expect_at(3, K_DMEM, 8,      32'h1234_5678, "sw_bytes8_11");
    expect_at(7, K_REG,  REG_S0, 32'h1234_5678, "lw_s0");
    expect_at(7, K_REG,  REG_S1, 32'h1234_5678, "lw_lowbits_s1");
    expect_at(7, K_REG,  5'd18,  32'h1234_5678, "lw_negoff_s2");
    start_prog();
    step(7);
    finish_prog();

    // ---- branches, jal/jr ----
    clear_prog();
    prog[0]  = enc_i(OP_ADDI, 5'd0, REG_T0, 16'd1);
    prog[1]  = enc_i(OP_ADDI, 5'd0, REG_T1, 16'd1);
    prog[2]  = enc_i(OP_BEQ,  REG_T0, REG_T1, 16'd1);
    prog[3]  = enc_i(OP_ADDI, 5'd0, REG_S0, 16'd99);
    prog[4]  = enc_i(OP_BNE,  REG_T0, REG_T1, 16'd1);
    prog[5]  = enc_i(OP_ADDI, 5'd0, REG_S1, 16'd5);
    prog[6]  = enc_j(OP_JAL,  26'h10);
    prog[7]  = enc_i(OP_ADDI, 5'd0, 5'd18, 16'd7);
    prog[8]  = enc_i(OP_BEQ,  5'd0, 5'd0, 16'hFFFF);
    prog[16] = enc_i(OP_ADDI, 5'd0, 5'd19, 16'd3);
    prog[17] = enc_r(FN_JR,   REG_RA, 5'd0, 5'd0, 5'd0);
    expect_at(3,  K_PC,  0,      32'h0000_0010, "beq_taken_pc");
    expect_at(4,  K_PC,  0,      32'h0000_0014, "bne_fallthru_pc");
    expect_at(6,  K_PC,  0,      32'h0000_0040, "jal_pc");
    expect_at(6,  K_REG, REG_RA, 32'h0000_001C, "jal_ra");
    expect_at(8,  K_PC,  0,      32'h0000_001C, "jr_pc");
    expect_at(10, K_PC,  0,      32'h0000_0020, "beq_back_pc");
    expect_at(10, K_REG, REG_S0, 32'h0000_0000, "beq_skipped_s0");
    expect_at(10, K_REG, REG_S1, 32'h0000_0005, "bne_s1");
    expect_at(10, K_REG, 5'd18,  32'h0000_0007, "ret_s2");
    expect_at(10, K_REG, 5'd19,  32'h0000_0003, "sub_s3");
    start_prog();
    step(10);
    finish_prog();

    // ---- $0, overflow, unsupported encodings ----
    clear_prog();
    prog[0] = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd5);
    prog[1] = enc_i(OP_ADDI, 5'd0, REG_S1, 16'd32);
    prog[2] = enc_i(OP_LUI,  5'd0, REG_T0, 16'h7FFF);
    prog[3] = enc_i(OP_ORI,  REG_T0, REG_T0, 16'hFFFF);
    prog[4] = enc_i(OP_ADDI, REG_T0, REG_T0, 16'd1);
    prog[5] = enc_i(6'h3F,   5'd0, REG_T0, 16'h1234);
    prog[6] = enc_r(6'h3F,   REG_T1, REG_T1, REG_T0, 5'd0);
    prog[7] = enc_i(6'h20,   5'd0, REG_T0, 16'd8);
    expect_at(1, K_REG, 0,      32'h0000_0000, "zero_reg");
    expect_at(2, K_REG, REG_S1, 32'h0000_0020, "zero_read_s1");
    expect_at(5, K_REG, REG_T0, 32'h8000_0000, "addi_overflow");
    expect_at(8, K_REG, REG_T0, 32'h8000_0000, "unsupported_nop_t0");
    expect_at(8, K_PC,  0,      32'h0000_0020, "unsupported_pc");
    start_prog();
    step(8);
    finish_prog();

    // ---- reset asserted between edges 2 and 3, then replay ----
    load_addi_prog();
    expect_at(2, K_REG, REG_S1, 32'h0000_0003, "pre_reset_s1");
    start_prog();
    step(2);
    finish_prog();
    reset = 1'b1;
    #1;
    check("midreset_pc", pc, 32'h0000_0000);
    check("midreset_instr", instr, 32'h2010_0000);
    for (int r = 0; r < 32; r++)
      check($sformatf("midreset_r%0d", r), dut.registers.registers[r], 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("reset_hold_pc", pc, 32'h0000_0000);
    check("reset_hold_s1", dut.registers.registers[REG_S1], 32'h0);
    expect_addi_final(4);
    reset = 1'b0;
    cyc = 0;
    step(4);
    finish_prog();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_single_cycle_cpu.md
Name: mips_single_cycle_cpu

Overview:
Single-cycle 32-bit MIPS-I subset processor: fetch, decode, execute, memory and writeback all complete in one clock.
Contains its own byte-addressed instruction memory, data memory and 32x32 register file.
Programs are loaded by backdoor into instruction memory.
Top-level core for the instruction-level test suite; state is checked hierarchically.

Parameters:
IMEM_BYTES, 1024, instruction memory size in bytes (power of two)
DMEM_BYTES, 1024, data memory size in bytes (power of two)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock for all state
reset  input  1  asynchronous, active-high; clears PC and register file
pc  output  32  current program counter
instr  output  32  instruction at current PC (combinational)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset: pc=RESET_PC; all 32 registers=0; instr reflects imem[RESET_PC]. Memory contents untouched by reset.
- Each rising edge with reset low commits exactly one instruction: register write, data-memory write and PC update all happen on that edge.
- The Nth edge after reset release commits the Nth instruction.
- Instruction memory is a byte array, big-endian: word = {b[a], b[a+1], b[a+2], b[a+3]}.
- Instruction address = pc mod IMEM_BYTES, with pc[1:0] ignored.
- Data memory: same byte layout; address mod DMEM_BYTES, low 2 bits ignored.
- Register $0 reads 0 always; writes to $0 are discarded.
- Supported instructions:
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type: addi, addiu, andi, ori, xori, slti, sltiu, lui, lw, sw, beq, bne.
  - J-type: j, jal (jal writes PC+4 to $31).
- Immediates: sign-extended for addi/addiu/slti/sltiu/lw/sw/beq/bne; zero-extended for andi/ori/xori; lui = imm<<16.
- Arithmetic wraps modulo 2^32; add/addi overflow raises no exception and the result is written.
- slt/slti compare signed; sltu/sltiu compare unsigned; result is 0 or 1.
- Next PC:
  - Default PC+4.
  - Taken branch: PC+4+(sext(imm)<<2).
  - j/jal: {PC+4[31:28], target, 2'b00}.
  - jr: rs.
- Unsupported opcode or funct: NOP (PC+4, no state change).
- No delay slots. No hazards, since single cycle.
- Reset asserted mid-program: PC and registers clear immediately, no commit on that edge; execution restarts from RESET_PC when reset is released.

Decomposition:
- Shared package mips_pkg:
  - opcode and funct localparams;
  - ALU-op enumeration;
  - register index constants REG_ZERO=0, REG_T0=8, REG_T1=9, REG_S0=16, REG_S1=17, REG_RA=31.
- Required instance hierarchy for bench backdoor access:
  - instruction fetch unit instance IFU, containing instance imemory, containing instance storage with byte array bytes[0:IMEM_BYTES-1];
  - register file instance registers with array registers[0:31].
- Natural sub-module: mips_regfile (2 async read ports, 1 sync write port, async reset clear). Control decoder and ALU may be inline or small modules.

Test Plan:
- addi load: program addi $s0,$0,0; addi $s1,$0,3; addi $t0,$0,255; addi $t1,$0,-3.
  - After 4 edges past reset: $s0=0, $s1=3, $t0=32'h000000FF, $t1=32'hFFFFFFFD.
- R-type: $t0=7, $t1=-2; execute add, sub, slt, sltu, nor into $s0..$s4.
  - Results: 5, 9, 0, 1, 32'h00000000 (nor of 7 and 0xFFFFFFFE).
- Memory: lui $t0,0x1234; ori $t0,$t0,0x5678; sw $t0,8($0); lw $s0,8($0).
  - $s0=32'h12345678; dmem bytes 8..11 = 12 34 56 78.
- Branch/jump:
  - beq with equal regs skips next instruction; bne with equal regs falls through.
  - jal to 0x40 sets $ra=PC+4 and pc=0x40; jr $ra returns.
- $0 and overflow:
  - addi $0,$0,5 leaves $0=0.
  - addi $t0,$t0,1 with $t0=32'h7FFFFFFF gives 32'h80000000 with no trap.
- Reset mid-run: assert reset between edges 2 and 3.
  - pc=RESET_PC and all registers 0 immediately.
  - After release, the program replays and produces the same final state.
